// File: rtl/regfile_access_arbiter_if.sv
// rtl/regfile_access_arbiter_if.sv - APB slave bus bundle for the register-file access arbiter
interface regfile_access_arbiter_if #(
  parameter int ADDR_W = 4
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [7:0]        pwdata;
  logic [7:0]        prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/regfile_access_arbiter.sv
// rtl/regfile_access_arbiter.sv - arbitrates the register-file write port between core and APB
// and serves APB reads with wait states, error responses and bounded starvation
module regfile_access_arbiter #(
  parameter int         ADDR_W       = 4,
  parameter int         NREGS        = 8,
  parameter int         STARVE_LIMIT = 4,
  parameter logic [7:0] RO_MASK      = 8'h00
) (
  input  logic                           clk,
  input  logic                           rst,
  regfile_access_arbiter_if.slave        apb,
  input  logic                           core_wr_req,
  input  logic [2:0]                     core_wr_addr,
  input  logic [7:0]                     core_wr_data,
  output logic                           core_wr_gnt,
  output logic                           rf_wr_en,
  output logic [2:0]                     rf_wr_addr,
  output logic [7:0]                     rf_wr_data,
  output logic [2:0]                     rf_rd_addr,
  input  logic [7:0]                     rf_rd_data
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W:0] NREGS_W = NREGS[ADDR_W:0];

  typedef enum logic [1:0] {IDLE, ARB, RESP} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_write;
  logic [7:0]        lat_wdata;
  logic [CNT_W-1:0]  starve_cnt;
  logic [7:0]        prdata_q;
  logic              pready_q;
  logic              pslverr_q;

  logic              setup;
  logic              err;
  logic              apb_win;
  logic              core_beats_apb;
  logic [7:0]        rd_value;

  assign setup = apb.psel && !apb.penable;
  assign err   = ({1'b0, lat_addr} >= NREGS_W) || (lat_write && RO_MASK[lat_addr[2:0]]);

  // A core write registered last cycle has not reached the array yet, so forward it.
  assign rd_value = (rf_wr_en && rf_wr_addr == lat_addr[2:0]) ? rf_wr_data : rf_rd_data;

  always_comb begin
    next_state     = state;
    apb_win        = 1'b0;
    core_beats_apb = 1'b0;
    case (state)
      IDLE: begin
        if (setup) next_state = ARB;
      end
      ARB: begin
        if (!apb.psel) begin
          next_state = IDLE;
        end else if (err || !lat_write) begin
          next_state = RESP;
        end else if (core_wr_req && starve_cnt < LIMIT) begin
          core_beats_apb = 1'b1;
        end else begin
          apb_win    = 1'b1;
          next_state = RESP;
        end
      end
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    core_wr_gnt = core_wr_req && !apb_win;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_addr   <= '0;
      lat_write  <= 1'b0;
      lat_wdata  <= 8'h00;
      starve_cnt <= '0;
      prdata_q   <= 8'h00;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= 3'd0;
      rf_wr_data <= 8'h00;
    end else begin
      state <= next_state;

      if (state == IDLE && setup) begin
        lat_addr  <= apb.paddr;
        lat_write <= apb.pwrite;
        lat_wdata <= apb.pwdata;
      end

      if (state != ARB || !apb.psel || apb_win) begin
        starve_cnt <= '0;
      end else if (core_beats_apb) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end

      if (apb_win) begin
        rf_wr_en   <= 1'b1;
        rf_wr_addr <= lat_addr[2:0];
        rf_wr_data <= lat_wdata;
      end else if (core_wr_req) begin
        rf_wr_en   <= 1'b1;
        rf_wr_addr <= core_wr_addr;
        rf_wr_data <= core_wr_data;
      end else begin
        rf_wr_en   <= 1'b0;
      end

      // Response fields live for exactly the single RESP cycle.
      if (state == ARB && next_state == RESP) begin
        pready_q  <= 1'b1;
        pslverr_q <= err;
        prdata_q  <= (err || lat_write) ? 8'h00 : rd_value;
      end else begin
        pready_q  <= 1'b0;
        pslverr_q <= 1'b0;
        prdata_q  <= 8'h00;
      end
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign rf_rd_addr  = lat_addr[2:0];

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// tb/tb_regfile_access_arbiter.sv - scoreboard bench with a transaction-level model of the arbiter
module tb_regfile_access_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam logic [7:0] RO = 8'h01;

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] d;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       core_wr_req;
  logic [2:0] core_wr_addr;
  logic [7:0] core_wr_data;
  logic       core_wr_gnt;
  logic       rf_wr_en;
  logic [2:0] rf_wr_addr;
  logic [7:0] rf_wr_data;
  logic [2:0] rf_rd_addr;
  logic [7:0] rf_rd_data;

  logic [7:0] rf_mem  [8] = '{default: 8'h00};
  logic [7:0] ref_mem [8] = '{default: 8'h00};

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int         core_mode = 0;
  logic [2:0] fix_addr = 3'd0;
  logic [7:0] fix_data = 8'h00;

  ent_t wq[$];
  ent_t rq[$];

  regfile_access_arbiter_if #(.ADDR_W(4)) apb_bus ();

  regfile_access_arbiter #(
    .ADDR_W(4), .NREGS(8), .STARVE_LIMIT(STARVE_LIMIT), .RO_MASK(RO)
  ) dut (
    .clk(clk), .rst(rst), .apb(apb_bus),
    .core_wr_req(core_wr_req), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
    .core_wr_gnt(core_wr_gnt),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;
  assign rf_rd_data = rf_mem[rf_rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Core stimulus, driven a little after the main driver so mode changes land in the same cycle.
  initial begin
    core_wr_req = 1'b0; core_wr_addr = 3'd0; core_wr_data = 8'h00;
    forever begin
      @(posedge clk); #2;
      case (core_mode)
        1: begin
          core_wr_req  = ($urandom_range(0, 99) < 55);
          core_wr_addr = 3'($urandom_range(0, 7));
          core_wr_data = 8'($urandom);
        end
        2: begin
          core_wr_req = 1'b1; core_wr_addr = fix_addr; core_wr_data = fix_data;
        end
        default: core_wr_req = 1'b0;
      endcase
    end
  end

  // Reference model: APB transaction phases, starvation count and register contents.
  int         m_phase = 0;
  int         m_cnt = 0;
  logic [3:0] m_addr;
  logic       m_wr;
  logic [7:0] m_data;
  always @(negedge clk) begin
    logic apb_won, m_err, exp_gnt;
    if (rst) begin
      m_phase = 0; m_cnt = 0;
      wq.delete(); rq.delete();
    end else begin
      apb_won = 1'b0;
      if (m_phase == 0) begin
        if (apb_bus.psel && !apb_bus.penable) begin
          m_addr = apb_bus.paddr; m_wr = apb_bus.pwrite; m_data = apb_bus.pwdata;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (!apb_bus.psel) begin
          m_phase = 0; m_cnt = 0;
        end else begin
          m_err = (m_addr >= 4'd8) || (m_wr && RO[m_addr[2:0]]);
          if (m_err) begin
            rq.push_back('{cyc, 8'h01, 8'h00}); m_phase = 2;
          end else if (!m_wr) begin
            rq.push_back('{cyc, 8'h00, ref_mem[m_addr[2:0]]}); m_phase = 2;
          end else if (core_wr_req && m_cnt < STARVE_LIMIT) begin
            m_cnt++;
          end else begin
            apb_won = 1'b1;
            rq.push_back('{cyc, 8'h00, 8'h00});
            wq.push_back('{cyc, {5'd0, m_addr[2:0]}, m_data});
            ref_mem[m_addr[2:0]] = m_data;
            m_cnt = 0; m_phase = 2;
          end
        end
      end else begin
        m_phase = 0; m_cnt = 0;
      end
      exp_gnt = core_wr_req && !apb_won;
      check("core_wr_gnt", core_wr_gnt, exp_gnt);
      if (exp_gnt) begin
        wq.push_back('{cyc, {5'd0, core_wr_addr}, core_wr_data});
        ref_mem[core_wr_addr] = core_wr_data;
      end
    end
  end

  // Monitor: every expected item must appear exactly one cycle after it was pushed.
  always @(negedge clk) begin
    if (!rst) begin
      while (wq.size() > 0 && wq[0].cyc < cyc - 1) begin
        check("rf_wr_missing", 0, 1); void'(wq.pop_front());
      end
      if (rf_wr_en) begin
        if (wq.size() > 0 && wq[0].cyc == cyc - 1) begin
          check("rf_wr_addr", rf_wr_addr, wq[0].a[2:0]);
          check("rf_wr_data", rf_wr_data, wq[0].d);
          void'(wq.pop_front());
        end else begin
          check("rf_wr_unexpected", rf_wr_en, 0);
        end
      end
      while (rq.size() > 0 && rq[0].cyc < cyc - 1) begin
        check("pready_missing", 0, 1); void'(rq.pop_front());
      end
      if (apb_bus.pready) begin
        if (rq.size() > 0 && rq[0].cyc == cyc - 1) begin
          check("pslverr", apb_bus.pslverr, rq[0].a[0]);
          check("prdata", apb_bus.prdata, rq[0].d);
          void'(rq.pop_front());
        end else begin
          check("pready_unexpected", apb_bus.pready, 0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      apb_bus.psel = 1'b0; apb_bus.penable = 1'b0;
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [7:0] data,
                          output int waits);
    @(posedge clk); #1;
    apb_bus.psel = 1'b1; apb_bus.penable = 1'b0;
    apb_bus.pwrite = wr; apb_bus.paddr = addr; apb_bus.pwdata = data;
    @(posedge clk); #1;
    apb_bus.penable = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!apb_bus.pready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!apb_bus.pready) check("apb_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int w;
    rst = 1'b1;
    apb_bus.psel = 1'b0; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b0;
    apb_bus.paddr = 4'd0; apb_bus.pwdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pready", apb_bus.pready, 0);
    check("reset_pslverr", apb_bus.pslverr, 0);
    check("reset_prdata", apb_bus.prdata, 0);
    check("reset_rf_wr_en", rf_wr_en, 0);
    check("reset_gnt", core_wr_gnt, 0);
    rst = 1'b0;

    // Uncontended write then read back.
    apb_xfer(1'b1, 4'd3, 8'hA5, w); check("wr_waits", w, 1);
    apb_xfer(1'b0, 4'd3, 8'h00, w); check("rd_waits", w, 1);
    idle(1);

    // Starvation bound with the core requesting every cycle.
    fix_addr = 3'd6; fix_data = 8'h77; core_mode = 2;
    apb_xfer(1'b1, 4'd1, 8'h11, w); check("starve_waits", w, STARVE_LIMIT + 1);
    core_mode = 0;
    idle(2);

    // Error responses: out of range and read-only register 0.
    apb_xfer(1'b1, 4'd9, 8'hEE, w); check("err_waits", w, 1);
    apb_xfer(1'b1, 4'd0, 8'hBB, w);
    apb_xfer(1'b0, 4'd0, 8'h00, w);
    apb_xfer(1'b0, 4'd12, 8'h00, w);
    idle(1);

    // Forwarding: core write to reg 2 granted in the setup cycle of a read of reg 2.
    @(posedge clk); #1;
    apb_bus.psel = 1'b1; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b0; apb_bus.paddr = 4'd2;
    fix_addr = 3'd2; fix_data = 8'h3C; core_mode = 2;
    @(posedge clk); #1;
    apb_bus.penable = 1'b1; core_mode = 0;
    @(negedge clk);
    check("fwd_ready_t1", apb_bus.pready, 0);
    @(negedge clk);
    check("fwd_ready_t2", apb_bus.pready, 1);
    check("fwd_prdata", apb_bus.prdata, 8'h3C);
    idle(2);

    // Abort: psel dropped in an ARB cycle the core is winning.
    fix_addr = 3'd4; fix_data = 8'h44; core_mode = 2;
    @(posedge clk); #1;
    apb_bus.psel = 1'b1; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b1;
    apb_bus.paddr = 4'd6; apb_bus.pwdata = 8'h66;
    @(posedge clk); #1;
    apb_bus.penable = 1'b1;
    idle(1);
    core_mode = 0;
    idle(3);
    check("abort_pready", apb_bus.pready, 0);
    apb_xfer(1'b0, 4'd6, 8'h00, w);
    idle(1);

    // Asynchronous reset during the ARB cycle of a write to reg 5.
    @(posedge clk); #1;
    apb_bus.psel = 1'b1; apb_bus.penable = 1'b0; apb_bus.pwrite = 1'b1;
    apb_bus.paddr = 4'd5; apb_bus.pwdata = 8'h5A;
    @(posedge clk); #1;
    apb_bus.penable = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_pready", apb_bus.pready, 0);
    check("rst_rf_wr_en", rf_wr_en, 0);
    check("rst_rf_wr_addr", rf_wr_addr, 0);
    check("rst_rf_wr_data", rf_wr_data, 0);
    check("rst_prdata", apb_bus.prdata, 0);
    apb_bus.psel = 1'b0; apb_bus.penable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    apb_xfer(1'b0, 4'd5, 8'h00, w);

    // Randomised traffic with the core contending at random.
    core_mode = 1;
    for (int i = 0; i < 80; i++) begin
      apb_xfer(1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)), 8'($urandom), w);
      idle($urandom_range(0, 2));
    end
    core_mode = 0;
    idle(6);
    check("wq_drained", wq.size(), 0);
    check("rq_drained", rq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
